// File: rtl/switch_alloc.sv
`default_nettype none
// ============================================================================
// Module   : switch_alloc
// Purpose  : Router output-port allocator. Each of the P crossbar outputs has
//            its own round-robin arbiter over the inputs requesting it. An
//            output is eligible only while its downstream credit counter is
//            non-zero. All outputs are registered, so a decision made from
//            port_req in cycle t appears on the outputs in cycle t+1.
// Ports    : clk        - clock
//            rst        - asynchronous active-high reset
//            port_req   - P*P request matrix, bit [i*P+o] = input i wants o
//            credit_in  - P credit-return pulses, one per released flit
//            grant      - P*P grants, bit [i*P+o] = output o granted to i
//            xbar_sel   - P*P crossbar selects, [o*P +: P] one-hot input
//            out_wr     - P per-output downstream write strobes
//            credit_err - sticky flag, credit returned while counter full
// Revision : 1.0 - initial release
// ============================================================================
module switch_alloc #(
    parameter int P = 7,
    parameter int B = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [P*P-1:0]   port_req,
    input  logic [P-1:0]     credit_in,
    output logic [P*P-1:0]   grant,
    output logic [P*P-1:0]   xbar_sel,
    output logic [P-1:0]     out_wr,
    output logic             credit_err
);

    localparam int         c_PW   = (P > 1) ? $clog2(P) : 1;
    localparam logic [B:0] c_CMAX = {1'b1, {B{1'b0}}};

    logic [B:0]      r_credit [P];
    logic [c_PW-1:0] r_ptr    [P];
    logic [P*P-1:0]  r_grant;
    logic [P*P-1:0]  r_sel;
    logic [P-1:0]    r_out_wr;
    logic            r_err;

    // Per-output arbitration results, packed so each generate iteration
    // drives only its own slice.
    logic [P-1:0]      w_win;
    logic [P*P-1:0]    w_onehot;
    logic [P*c_PW-1:0] w_next_ptr;

    for (genvar o = 0; o < P; o++) begin : g_out
        logic [P-1:0]    w_col;
        logic [P-1:0]    w_mask;
        logic [P-1:0]    w_masked;
        logic [P-1:0]    w_src;
        logic [P-1:0]    w_pick;
        logic [c_PW-1:0] w_idx;

        // Column o of the request matrix, plus a mask of inputs at or
        // above the pointer. Searching the masked set first and falling
        // back to the full set gives the wrap-around scan.
        always_comb begin
            w_col  = '0;
            w_mask = '0;
            for (int i = 0; i < P; i++) begin
                w_col[i]  = port_req[i*P+o];
                w_mask[i] = (i >= int'(r_ptr[o]));
            end
        end

        assign w_masked = w_col & w_mask;
        assign w_src    = (|w_masked) ? w_masked : w_col;
        // Isolate the lowest set bit.
        assign w_pick   = w_src & (~w_src + P'(1));

        always_comb begin
            w_idx = '0;
            for (int i = 0; i < P; i++) begin
                if (w_pick[i]) begin
                    w_idx = c_PW'(i);
                end
            end
        end

        assign w_win[o]                   = (|w_col) && (r_credit[o] != '0);
        assign w_onehot[o*P +: P]         = w_pick;
        assign w_next_ptr[o*c_PW +: c_PW] = (w_idx == c_PW'(P-1)) ? '0
                                          : w_idx + c_PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant  <= '0;
            r_sel    <= '0;
            r_out_wr <= '0;
            r_err    <= 1'b0;
            for (int o = 0; o < P; o++) begin
                r_credit[o] <= c_CMAX;
                r_ptr[o]    <= '0;
            end
        end else begin
            r_out_wr <= w_win;
            for (int o = 0; o < P; o++) begin
                r_sel[o*P +: P] <= w_win[o] ? w_onehot[o*P +: P] : '0;
                for (int i = 0; i < P; i++) begin
                    r_grant[i*P+o] <= w_win[o] & w_onehot[o*P+i];
                end
                if (w_win[o]) begin
                    r_ptr[o] <= w_next_ptr[o*c_PW +: c_PW];
                end
                // Consume and return together leave the counter unchanged.
                if (w_win[o] && !credit_in[o]) begin
                    r_credit[o] <= r_credit[o] - (B+1)'(1);
                end else if (!w_win[o] && credit_in[o]) begin
                    if (r_credit[o] == c_CMAX) begin
                        r_err <= 1'b1;
                    end else begin
                        r_credit[o] <= r_credit[o] + (B+1)'(1);
                    end
                end
            end
        end
    end

    assign grant      = r_grant;
    assign xbar_sel   = r_sel;
    assign out_wr     = r_out_wr;
    assign credit_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_switch_alloc.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_alloc
// Purpose  : Self-checking bench for switch_alloc. Directed scenarios and a
//            random phase are compared cycle by cycle against a behavioural
//            allocator model kept in this file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_alloc;

    localparam int P    = 7;
    localparam int B    = 4;
    localparam int CMAX = 16;

    logic             clk;
    logic             rst;
    logic [P*P-1:0]   port_req;
    logic [P-1:0]     credit_in;
    logic [P*P-1:0]   grant;
    logic [P*P-1:0]   xbar_sel;
    logic [P-1:0]     out_wr;
    logic             credit_err;

    switch_alloc #(.P(P), .B(B)) dut (
        .clk        (clk),
        .rst        (rst),
        .port_req   (port_req),
        .credit_in  (credit_in),
        .grant      (grant),
        .xbar_sel   (xbar_sel),
        .out_wr     (out_wr),
        .credit_err (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int             m_credit [P];
    int             m_ptr    [P];
    bit             m_err;
    logic [P*P-1:0] e_grant;
    logic [P*P-1:0] e_sel;
    logic [P-1:0]   e_wr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < P; o++) begin
            m_credit[o] = CMAX;
            m_ptr[o]    = 0;
        end
        m_err = 1'b0;
    endtask

    // Called just after a negedge: apply inputs, predict, check after posedge.
    task automatic step(input logic [P*P-1:0] req, input logic [P-1:0] cin);
        port_req  = req;
        credit_in = cin;
        e_grant = '0;
        e_sel   = '0;
        e_wr    = '0;
        for (int o = 0; o < P; o++) begin
            bit won;
            won = 1'b0;
            if (m_credit[o] > 0) begin
                for (int k = 0; k < P; k++) begin
                    int i;
                    i = (m_ptr[o] + k) % P;
                    if (!won && req[i*P+o]) begin
                        won = 1'b1;
                        e_grant[i*P+o] = 1'b1;
                        e_sel[o*P+i]   = 1'b1;
                        e_wr[o]        = 1'b1;
                        m_ptr[o]       = (i + 1) % P;
                    end
                end
            end
            if (won && !cin[o]) begin
                m_credit[o] = m_credit[o] - 1;
            end else if (!won && cin[o]) begin
                if (m_credit[o] == CMAX) m_err = 1'b1;
                else m_credit[o] = m_credit[o] + 1;
            end
        end
        @(posedge clk);
        #1;
        chk("grant",      64'(grant),      64'(e_grant));
        chk("xbar_sel",   64'(xbar_sel),   64'(e_sel));
        chk("out_wr",     64'(out_wr),     64'(e_wr));
        chk("credit_err", 64'(credit_err), 64'(m_err));
        @(negedge clk);
    endtask

    function automatic logic [P*P-1:0] rq(input int i, input int o);
        logic [P*P-1:0] v;
        v = '0;
        v[i*P+o] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [P*P-1:0] req;
        int             seq [3];
        int             cnt;
        int             first_idle;
        logic [63:0]    r1;
        logic [63:0]    r2;

        seq[0] = 0; seq[1] = 3; seq[2] = 6;
        rst       = 1'b1;
        port_req  = '0;
        credit_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_grant", 64'(grant),      64'd0);
        chk("rst_sel",   64'(xbar_sel),   64'd0);
        chk("rst_wr",    64'(out_wr),     64'd0);
        chk("rst_err",   64'(credit_err), 64'd0);
        rst = 1'b0;

        // Single unicast: input 2 -> output 5
        step(rq(2, 5), '0);
        chk("uni_grant19", 64'(grant), 64'd1 << 19);
        chk("uni_sel37",   64'(xbar_sel[5*P+2]), 64'd1);
        chk("uni_wr",      64'(out_wr), 64'b0100000);
        step('0, '0);
        // ptr[5] now 3: inputs 2 and 3 request, 3 must win
        step(rq(2, 5) | rq(3, 5), '0);
        chk("uni_ptr", 64'(grant), 64'd1 << (3*P+5));

        // Round-robin fairness on output 1 with steady credit return
        req = rq(0, 1) | rq(3, 1) | rq(6, 1);
        for (int c = 0; c < 6; c++) begin
            step(req, 7'b0000010);
            chk("rr_order", 64'(grant), 64'(rq(seq[c % 3], 1)));
        end
        step('0, '0);

        // Multicast: set ptr[2]=3 first
        step(rq(2, 2), '0);
        step(rq(1, 0) | rq(1, 2) | rq(1, 6) | rq(5, 2), '0);
        chk("mc_grant", 64'(grant), (64'd1 << 7) | (64'd1 << 13) | (64'd1 << 37));
        step(rq(1, 2), '0);
        chk("mc_second", 64'(grant), 64'd1 << 9);

        // Simultaneous consume/return at CMAX on output 3, then overflow
        step(rq(0, 3), 7'b0001000);
        chk("sim_err0", 64'(credit_err), 64'd0);
        step('0, 7'b0001000);
        chk("ovf_err1", 64'(credit_err), 64'd1);
        step('0, '0);
        step('0, '0);
        chk("ovf_sticky", 64'(credit_err), 64'd1);

        // Credit exhaustion on output 0 (input 4); credit[0] has 15 left
        // after the multicast grant, so count all grants from here.
        cnt = 0;
        first_idle = -1;
        for (int c = 0; c < 20; c++) begin
            step(rq(4, 0), '0);
            if (out_wr[0]) cnt++;
            else if (first_idle < 0) first_idle = c;
        end
        chk("exh_count", 64'(cnt), 64'd15);
        chk("exh_idle",  64'(first_idle), 64'd15);
        step(rq(4, 0), 7'b0000001);
        chk("exh_pulse0", 64'(out_wr[0]), 64'd0);
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            step(rq(4, 0), '0);
            if (c == 0) chk("exh_pulse1", 64'(out_wr[0]), 64'd1);
            if (out_wr[0]) cnt++;
        end
        chk("exh_one_more", 64'(cnt), 64'd1);

        // Asynchronous reset mid-traffic
        step(rq(0, 2) | rq(3, 4) | rq(5, 6), '0);
        port_req = rq(0, 2) | rq(3, 4);
        #1 rst = 1'b1;
        #1;
        chk("arst_grant", 64'(grant),      64'd0);
        chk("arst_sel",   64'(xbar_sel),   64'd0);
        chk("arst_wr",    64'(out_wr),     64'd0);
        chk("arst_err",   64'(credit_err), 64'd0);
        model_reset();
        port_req = '0;
        @(negedge clk);
        rst = 1'b0;
        // Pointers back at 0: every input requests output 4, input 0 wins
        req = '0;
        for (int i = 0; i < P; i++) req = req | rq(i, 4);
        step(req, '0);
        chk("arst_ptr", 64'(grant), 64'd1 << 4);
        // Counters back at CMAX: output 0 grants 16 times in a row
        cnt = 0;
        for (int c = 0; c < 18; c++) begin
            step(rq(4, 0), '0);
            if (out_wr[0]) cnt++;
        end
        chk("arst_credit", 64'(cnt), 64'd16);

        // Random traffic against the model
        for (int c = 0; c < 300; c++) begin
            r1 = {$urandom(), $urandom()};
            r2 = {$urandom(), $urandom()};
            step(P*P'(r1 & r2), P'($urandom() & $urandom() & $urandom()));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
